// File: rtl/upload_arbiter_if.sv
// Upload arbiter bus: per-source message status, source FIFO read side, and the
// word stream toward the slave-FIFO writer. The arbiter uses the master modport;
// the sources and writer sit on the slave modport.
interface upload_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int LEN_W   = 8,
  parameter int SRC_W   = 4
);
  logic [NUM_SRC-1:0]       GOT_FULL_MSG;
  logic [NUM_SRC*LEN_W-1:0] MSG_LEN_BUS;
  logic [NUM_SRC*16-1:0]    FIFO_Q_BUS;
  logic                     DOUT_READY;
  logic [NUM_SRC-1:0]       MSG_START;
  logic [NUM_SRC-1:0]       RD_REQ;
  logic [15:0]              DOUT;
  logic                     DOUT_VALID;
  logic                     PKT_END;
  logic                     BUSY;
  logic [SRC_W-1:0]         CUR_SRC;

  modport master (
    input  GOT_FULL_MSG, MSG_LEN_BUS, FIFO_Q_BUS, DOUT_READY,
    output MSG_START, RD_REQ, DOUT, DOUT_VALID, PKT_END, BUSY, CUR_SRC
  );

  modport slave (
    output GOT_FULL_MSG, MSG_LEN_BUS, FIFO_Q_BUS, DOUT_READY,
    input  MSG_START, RD_REQ, DOUT, DOUT_VALID, PKT_END, BUSY, CUR_SRC
  );
endinterface

// File: rtl/upload_arbiter.sv
// Round-robin scheduler sharing the single slave-FIFO upload path among all
// SPI/UART sources. Grants one source holding a complete message, pulses its
// MSG_START, reads its words (1-clk source read latency) and flags the last word
// with PKT_END.
// Optional feature: define UPLOAD_HDR_EN to emit one header word
// {source index, length[7:0]} ahead of each message's payload.
module upload_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int LEN_W   = 8,
  parameter int SRC_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  upload_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, GRANT, HDR, DATA, DRAIN} state_t;

  state_t           state, state_nx;
  logic [SRC_W-1:0] ptr, cur_src, pick_idx;
  logic [LEN_W-1:0] cnt, pick_len;
  logic             pick_vld;
  logic             rd_any;
  logic [15:0]      q_sel;
  logic             rd_vld_p0;
  logic [15:0]      dout_p1;
  logic             vld_p1;
  logic             end_p1;

`ifdef UPLOAD_HDR_EN
  function automatic logic [15:0] hdr_word(input logic [SRC_W-1:0] src,
                                           input logic [LEN_W-1:0] len);
    return {8'(src), 8'(len)};
  endfunction
`endif

  // Rotating search: first requesting source after the last granted one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_len = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!pick_vld && bus.GOT_FULL_MSG[i] && (i == (int'(ptr) + k) % NUM_SRC)) begin
          pick_vld = 1'b1;
          pick_idx = SRC_W'(i);
          pick_len = bus.MSG_LEN_BUS[i*LEN_W +: LEN_W];
        end
      end
    end
  end

  // Read data mux for the currently granted source.
  always_comb begin
    q_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_src == SRC_W'(i)) q_sel = bus.FIFO_Q_BUS[i*16 +: 16];
    end
  end

  assign rd_any = (state == DATA) && bus.DOUT_READY && (cnt != '0);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (pick_vld) state_nx = GRANT;
`ifdef UPLOAD_HDR_EN
      GRANT: state_nx = HDR;
      HDR:   if (bus.DOUT_READY) state_nx = (cnt != '0) ? DATA : IDLE;
`else
      GRANT: state_nx = (cnt != '0) ? DATA : IDLE;
`endif
      DATA:  if (rd_any && (cnt == LEN_W'(1))) state_nx = DRAIN;
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant bookkeeping, word counter and the output word pipeline.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr       <= '0;
      cur_src   <= '0;
      cnt       <= '0;
      rd_vld_p0 <= 1'b0;
      dout_p1   <= '0;
      vld_p1    <= 1'b0;
      end_p1    <= 1'b0;
    end else begin
      if ((state == IDLE) && pick_vld) begin
        cur_src <= pick_idx;
        cnt     <= pick_len;
      end
      if (state == GRANT) ptr <= cur_src;
      if (rd_any) cnt <= cnt - LEN_W'(1);

      // p0: read strobe issued, source data arrives next clk
      rd_vld_p0 <= rd_any;

      // p1: capture source word toward the writer
      vld_p1 <= rd_vld_p0;
      end_p1 <= (state == DRAIN);
      if (rd_vld_p0) dout_p1 <= q_sel;
`ifdef UPLOAD_HDR_EN
      if ((state == HDR) && bus.DOUT_READY) begin
        dout_p1 <= hdr_word(cur_src, cnt);
        vld_p1  <= 1'b1;
        end_p1  <= (cnt == '0);
      end
`endif
    end
  end

  assign bus.MSG_START  = (state == GRANT) ? (NUM_SRC'(1) << cur_src) : '0;
  assign bus.RD_REQ     = rd_any ? (NUM_SRC'(1) << cur_src) : '0;
  assign bus.DOUT       = dout_p1;
  assign bus.DOUT_VALID = vld_p1;
  assign bus.PKT_END    = end_p1;
  assign bus.BUSY       = (state != IDLE);
  assign bus.CUR_SRC    = cur_src;

endmodule

// File: tb/tb_upload_arbiter.sv
// Scoreboard bench for upload_arbiter: source FIFO model with 1-clk read latency,
// expected words queued when messages are posted, compared as they leave DOUT.
module tb_upload_arbiter;
  localparam int NS = 4;
  localparam int LW = 8;
  localparam int SW = 4;
`ifdef UPLOAD_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  upload_arbiter_if #(.NUM_SRC(NS), .LEN_W(LW), .SRC_W(SW)) bus();

  upload_arbiter #(.NUM_SRC(NS), .LEN_W(LW), .SRC_W(SW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [15:0] q_arr [NS];
  logic [7:0]  len_arr [NS];
  int          rdcnt [NS];

  assign bus.FIFO_Q_BUS  = {q_arr[3], q_arr[2], q_arr[1], q_arr[0]};
  assign bus.MSG_LEN_BUS = {len_arr[3], len_arr[2], len_arr[1], len_arr[0]};

  function automatic logic [15:0] mkword(input int s, input int n);
    return 16'((s << 12) | ((n ^ 'h5A5) & 'hFFF));
  endfunction

  // Source FIFO model: word appears one clk after the read strobe.
  always begin : src_model
    logic [NS-1:0] rd;
    @(posedge CLK);
    rd = bus.RD_REQ;
    #1;
    for (int i = 0; i < NS; i++) begin
      if (!RST) begin
        rdcnt[i] = 0;
        q_arr[i] = 16'h0;
      end else if (rd[i]) begin
        q_arr[i] = mkword(i, rdcnt[i]);
        rdcnt[i] = rdcnt[i] + 1;
      end
    end
  end

  int          n_chk = 0;
  int          n_err = 0;
  logic [16:0] sb [$];
  int          grants [$];
  int          vld_cnt = 0;
  int          pkt_cnt = 0;
  int          viol = 0;
  int          rd_tot [NS];
  int          exp_seq [NS];
  bit          auto_clr = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic exp_msg(input int s, input int len);
    if (HDR != 0) sb.push_back({(len == 0), 8'(s), 8'(len)});
    for (int k = 0; k < len; k++) begin
      sb.push_back({(k == len - 1), mkword(s, exp_seq[s])});
      exp_seq[s]++;
    end
  endtask

  task automatic post(input int s, input int len);
    len_arr[s] = 8'(len);
    bus.GOT_FULL_MSG = bus.GOT_FULL_MSG | (4'b0001 << s);
  endtask

  task automatic wait_grants(input int target, input string tag);
    int k;
    for (k = 0; k < 100; k++) begin
      if (grants.size() >= target) break;
      @(negedge CLK); #1;
    end
    if (k == 100) check_val({tag, "_grant_timeout"}, 1, 0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge CLK); #1;
      if (!bus.BUSY && (sb.size() == 0)) break;
    end
    if (k == 300) check_val({tag, "_idle_timeout"}, 1, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_msg_start"}, 32'(bus.MSG_START), 0);
    check_val({tag, "_rd_req"}, 32'(bus.RD_REQ), 0);
    check_val({tag, "_dout"}, 32'(bus.DOUT), 0);
    check_val({tag, "_dout_valid"}, 32'(bus.DOUT_VALID), 0);
    check_val({tag, "_pkt_end"}, 32'(bus.PKT_END), 0);
    check_val({tag, "_busy"}, 32'(bus.BUSY), 0);
    check_val({tag, "_cur_src"}, 32'(bus.CUR_SRC), 0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    bus.GOT_FULL_MSG = '0;
    sb.delete();
    for (int i = 0; i < NS; i++) exp_seq[i] = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  initial begin
    int gb, vb, pb, n;
    int rb [NS];
    int ord [5] = '{1, 2, 3, 0, 1};

    bus.GOT_FULL_MSG = '0;
    bus.DOUT_READY   = 1'b1;
    for (int i = 0; i < NS; i++) begin
      len_arr[i] = '0;
      rd_tot[i]  = 0;
      exp_seq[i] = 0;
    end

    fork
      forever begin
        @(negedge CLK);
        if (bus.DOUT_VALID) begin
          vld_cnt++;
          if (bus.PKT_END) pkt_cnt++;
          if (sb.size() == 0) check_val("dout_unexpected", 1, 0);
          else                check_val("dout_word", {15'h0, bus.PKT_END, bus.DOUT}, 32'(sb.pop_front()));
        end
        if (bus.PKT_END && !bus.DOUT_VALID) viol++;
        if (($countones(bus.RD_REQ) > 1) || ($countones(bus.MSG_START) > 1)) viol++;
        if ((bus.RD_REQ != '0) && !bus.DOUT_READY) viol++;
        for (int i = 0; i < NS; i++) begin
          if (bus.RD_REQ[i]) rd_tot[i]++;
          if (bus.MSG_START[i]) begin
            grants.push_back(i);
            if (auto_clr) bus.GOT_FULL_MSG[i] = 1'b0;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge CLK);
    #1 check_zero_outputs("reset");
    RST = 1'b1;

    // Single message from source 1
    @(posedge CLK); #1;
    gb = grants.size(); vb = vld_cnt; pb = pkt_cnt; rb[1] = rd_tot[1];
    exp_msg(1, 3);
    post(1, 3);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.DOUT_VALID) break;
      n++;
    end
    check_val("single_latency", 32'(n), 32'(4 - HDR));
    wait_idle("single");
    check_val("single_grants", 32'(grants.size() - gb), 1);
    check_val("single_grant_src", 32'(grants[gb]), 1);
    check_val("single_rd_cnt", 32'(rd_tot[1] - rb[1]), 3);
    check_val("single_words", 32'(vld_cnt - vb), 32'(3 + HDR));
    check_val("single_pkt_end", 32'(pkt_cnt - pb), 1);
    check_val("single_cur_src", 32'(bus.CUR_SRC), 1);

    // Round-robin: all four request, len=1, held
    do_reset();
    auto_clr = 1'b0;
    gb = grants.size();
    for (int k = 0; k < 5; k++) exp_msg(ord[k], 1);
    for (int s = 0; s < NS; s++) post(s, 1);
    wait_grants(gb + 5, "rr");
    bus.GOT_FULL_MSG = '0;
    auto_clr = 1'b1;
    wait_idle("rr");
    check_val("rr_grant_total", 32'(grants.size() - gb), 5);
    for (int k = 0; k < 5; k++) check_val($sformatf("rr_order%0d", k), 32'(grants[gb + k]), 32'(ord[k]));

    // Backpressure on source 0, len=5
    gb = grants.size(); vb = vld_cnt; rb[0] = rd_tot[0];
    exp_msg(0, 5);
    post(0, 5);
    n = 0;
    for (n = 0; n < 50; n++) begin
      @(negedge CLK); #1;
      if (rd_tot[0] - rb[0] >= 2) break;
    end
    if (n == 50) check_val("bp_rd_timeout", 1, 0);
    @(posedge CLK); #1 bus.DOUT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1 bus.DOUT_READY = 1'b1;
    wait_idle("bp");
    check_val("bp_grant_src", 32'(grants[gb]), 0);
    check_val("bp_rd_cnt", 32'(rd_tot[0] - rb[0]), 5);
    check_val("bp_words", 32'(vld_cnt - vb), 32'(5 + HDR));

    // Zero-length message from source 2
    gb = grants.size(); vb = vld_cnt; pb = pkt_cnt;
    for (int i = 0; i < NS; i++) rb[i] = rd_tot[i];
    exp_msg(2, 0);
    post(2, 0);
    wait_grants(gb + 1, "zero");
    wait_idle("zero");
    check_val("zero_grant_src", 32'(grants[gb]), 2);
    check_val("zero_rd_cnt", 32'((rd_tot[0] - rb[0]) + (rd_tot[1] - rb[1]) +
                                 (rd_tot[2] - rb[2]) + (rd_tot[3] - rb[3])), 0);
    check_val("zero_words", 32'(vld_cnt - vb), 32'(HDR));
    check_val("zero_pkt_end", 32'(pkt_cnt - pb), 32'(HDR));

    // Reset in the middle of a 6-word message from source 1
    vb = vld_cnt; pb = pkt_cnt;
    exp_msg(1, 6);
    post(1, 6);
    for (n = 0; n < 50; n++) begin
      @(negedge CLK); #1;
      if (vld_cnt - vb >= 2 + HDR) break;
    end
    if (n == 50) check_val("rst_words_timeout", 1, 0);
    #2 RST = 1'b0;
    #1 check_zero_outputs("midrst");
    sb.delete();
    bus.GOT_FULL_MSG = '0;
    for (int i = 0; i < NS; i++) exp_seq[i] = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    check_val("midrst_pkt_end", 32'(pkt_cnt - pb), 0);

    // Pointer back at 0: source 1 must win over source 0
    gb = grants.size();
    exp_msg(1, 1);
    exp_msg(0, 1);
    post(0, 1);
    post(1, 1);
    wait_grants(gb + 2, "ptr");
    wait_idle("ptr");
    check_val("ptr_first", 32'(grants[gb]), 1);
    check_val("ptr_second", 32'(grants[gb + 1]), 0);

    check_val("protocol_viol", 32'(viol), 0);
    check_val("sb_left", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
